// File: rtl/n64_poll_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : n64_poll_scheduler
//  Purpose  : Round-robin scheduler that shares one N64 request engine and one
//             receive engine across NUM_PORTS controller lines. It starts one
//             polling round per POLL_PERIOD, times out absent controllers and
//             latches each port's 32-bit response word.
//  Options  : N64_IDENTITY_PROBE_EN - absent ports receive identity requests
//             (req_type 0) instead of data requests. A good identity reply
//             marks the port present without touching its data word.
//  Revision : 1.0  initial release
// ============================================================================
module n64_poll_scheduler #(
  parameter int NUM_PORTS   = 4,
  parameter int POLL_PERIOD = 800000,
  parameter int RX_TIMEOUT  = 10000,
  parameter int GAP_CYCLES  = 100
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  output logic                    req_trigger,
  output logic                    req_type,
  input  logic                    req_busy,
  output logic                    rx_trigger,
  output logic                    rx_abort,
  input  logic                    rx_busy,
  input  logic [31:0]             rx_data,
  output logic [2:0]              port_sel,
  output logic                    drive_en,
  output logic [32*NUM_PORTS-1:0] controller_data,
  output logic [NUM_PORTS-1:0]    port_present,
  output logic [NUM_PORTS-1:0]    new_data,
  output logic                    round_done
);

  localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int TW = $clog2(RX_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [PW-1:0] PERIOD_LOAD  = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(RX_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST     = GW'(GAP_CYCLES - 1);
  localparam logic [2:0]    LAST_PORT    = 3'(NUM_PORTS - 1);

  localparam logic [2:0] ST_WAIT_PERIOD = 3'd0;
  localparam logic [2:0] ST_SEND        = 3'd1;
  localparam logic [2:0] ST_SEND_WAIT   = 3'd2;
  localparam logic [2:0] ST_RECV_WAIT   = 3'd3;
  localparam logic [2:0] ST_STORE       = 3'd4;
  localparam logic [2:0] ST_GAP         = 3'd5;

  logic [2:0]           state;
  logic [PW-1:0]        period_cnt;
  logic                 period_tick;
  logic                 start_pending;
  logic                 start_now;
  logic                 gap_done;
  logic                 identity_slot;
  logic [TW-1:0]        timeout_cnt;
  logic [GW-1:0]        gap_cnt;
  logic [NUM_PORTS-1:0] sel_onehot;

  // Engine hand-off strobes are pure functions of the state register.
  assign req_trigger = (state == ST_SEND);
  assign drive_en    = (state == ST_SEND) || (state == ST_SEND_WAIT);

  assign period_tick = (period_cnt == '0);
  assign start_now   = (state == ST_WAIT_PERIOD) && (period_tick || start_pending);
  assign gap_done    = (state == ST_GAP) && (gap_cnt == GAP_LAST);

  // Decode the selected port into a one-hot mask for per-port updates.
  always_comb begin
    sel_onehot = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      sel_onehot[p] = (port_sel == 3'(p));
    end
  end

  // Free-running period counter; a round is due every time it wraps.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || period_tick) begin
      period_cnt <= PERIOD_LOAD;
    end else begin
      period_cnt <= period_cnt - PW'(1);
    end
  end

  // Remember a period wrap that lands mid-round (single-depth, never queued twice).
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      start_pending <= 1'b0;
    end else if (state == ST_WAIT_PERIOD) begin
      start_pending <= 1'b0;
    end else if (period_tick) begin
      start_pending <= 1'b1;
    end
  end

`ifdef N64_IDENTITY_PROBE_EN
  logic                 req_type_q;
  logic [NUM_PORTS-1:0] next_onehot;

  // One-hot of the port that follows the current one in the round.
  always_comb begin
    next_onehot = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      next_onehot[p] = ((port_sel + 3'd1) == 3'(p));
    end
  end

  // Pick the request kind for the upcoming slot from that port's presence.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      req_type_q <= 1'b1;
    end else if (start_now) begin
      req_type_q <= port_present[0];
    end else if (gap_done && (port_sel != LAST_PORT)) begin
      req_type_q <= |(port_present & next_onehot);
    end
  end

  assign req_type      = req_type_q;
  assign identity_slot = ~req_type_q;
`else
  assign req_type      = 1'b1;
  assign identity_slot = 1'b0;
`endif

  // Main sequencer: walks every port through request, receive, store and gap.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state           <= ST_WAIT_PERIOD;
      port_sel        <= 3'd0;
      rx_trigger      <= 1'b0;
      rx_abort        <= 1'b0;
      new_data        <= '0;
      round_done      <= 1'b0;
      timeout_cnt     <= '0;
      gap_cnt         <= '0;
      controller_data <= '0;
      port_present    <= '0;
    end else begin
      rx_trigger <= 1'b0;
      rx_abort   <= 1'b0;
      new_data   <= '0;
      round_done <= 1'b0;
      case (state)
        ST_WAIT_PERIOD: begin
          if (start_now) begin
            port_sel <= 3'd0;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          state <= ST_SEND_WAIT;
        end
        ST_SEND_WAIT: begin
          // req_trigger is already low here, so busy is sampled after the pulse.
          if (!req_busy) begin
            rx_trigger  <= 1'b1;
            timeout_cnt <= '0;
            state       <= ST_RECV_WAIT;
          end
        end
        ST_RECV_WAIT: begin
          timeout_cnt <= timeout_cnt + TW'(1);
          // Completion is tested first so it wins over a simultaneous timeout.
          if (!rx_trigger && !rx_busy) begin
            state <= ST_STORE;
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            rx_abort     <= 1'b1;
            port_present <= port_present & ~sel_onehot;
            gap_cnt      <= '0;
            state        <= ST_GAP;
          end
        end
        ST_STORE: begin
          port_present <= port_present | sel_onehot;
          if (!identity_slot) begin
            new_data <= sel_onehot;
            for (int p = 0; p < NUM_PORTS; p++) begin
              if (sel_onehot[p]) begin
                controller_data[32*p +: 32] <= rx_data;
              end
            end
          end
          gap_cnt <= '0;
          state   <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (port_sel == LAST_PORT) begin
              round_done <= 1'b1;
              state      <= ST_WAIT_PERIOD;
            end else begin
              port_sel <= port_sel + 3'd1;
              state    <= ST_SEND;
            end
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: begin
          state <= ST_WAIT_PERIOD;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_n64_poll_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_n64_poll_scheduler
//  Purpose  : Self-checking bench for n64_poll_scheduler. Behavioural request
//             and receive engines answer each slot; a round-level model
//             predicts presence, data words, new_data order and aborts.
//  Revision : 1.0  initial release
// ============================================================================
module tb_n64_poll_scheduler;

  localparam int NP  = 4;
  localparam int PER = 1500;
  localparam int TMO = 40;
  localparam int GAP = 6;
  localparam int CLK = 10;
`ifdef N64_IDENTITY_PROBE_EN
  localparam bit PROBE = 1'b1;
`else
  localparam bit PROBE = 1'b0;
`endif

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              req_trigger, req_type, req_busy;
  logic              rx_trigger, rx_abort, rx_busy;
  logic [31:0]       rx_data;
  logic [2:0]        port_sel;
  logic              drive_en;
  logic [32*NP-1:0]  controller_data;
  logic [NP-1:0]     port_present, new_data;
  logic              round_done;

  n64_poll_scheduler #(
    .NUM_PORTS(NP), .POLL_PERIOD(PER), .RX_TIMEOUT(TMO), .GAP_CYCLES(GAP)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .req_trigger(req_trigger), .req_type(req_type), .req_busy(req_busy),
    .rx_trigger(rx_trigger), .rx_abort(rx_abort), .rx_busy(rx_busy),
    .rx_data(rx_data), .port_sel(port_sel), .drive_en(drive_en),
    .controller_data(controller_data), .port_present(port_present),
    .new_data(new_data), .round_done(round_done)
  );

  always #(CLK/2) sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  // Per-slot stimulus configuration
  int          rx_len [NP];
  bit          stuck  [NP];
  logic [31:0] word   [NP];
  int          req_len;

  // Reference model state
  logic [31:0] m_data    [NP];
  bit          m_present [NP];
  bit          m_rtype   [NP];
  int          exp_nd[$];
  int          got_nd[$];
  int          aborts;
  int          exp_aborts;
  time         ref_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural engines, updated away from the active edge.
  initial begin : engines
    int req_cnt;
    int rx_cnt;
    int cur_port;
    bit hold;
    req_cnt = 0; rx_cnt = 0; cur_port = 0; hold = 0; req_len = 2;
    req_busy = 1'b0; rx_busy = 1'b0; rx_data = 32'h0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        req_cnt = 0; rx_cnt = 0; hold = 0;
      end else begin
        if (req_trigger) begin
          req_len = $urandom_range(2, 6);
          req_cnt = req_len;
        end else if (req_cnt > 0) begin
          req_cnt--;
        end
        if (rx_abort) begin
          rx_cnt = 0; hold = 0;
        end
        if (rx_trigger && port_sel < NP) begin
          cur_port = int'(port_sel);
          hold     = stuck[cur_port];
          rx_cnt   = hold ? 1 : rx_len[cur_port];
          rx_data  = $urandom();
        end else if (rx_cnt > 0 && !hold) begin
          rx_cnt--;
          if (rx_cnt == 0) rx_data = word[cur_port];
        end
      end
      req_busy = (req_cnt > 0);
      rx_busy  = (rx_cnt > 0);
    end
  end

  // Continuous protocol observer: start timing, drive window, aborts, new_data.
  initial begin : monitor
    int  run;
    time t_trig;
    run = 0; t_trig = 0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        run = 0;
      end else begin
        if (req_trigger) begin
          check("port_sel_range", port_sel < NP, 1'b1);
          if (port_sel < NP) check("req_type", req_type, m_rtype[port_sel]);
          if (port_sel == 3'd0) begin
            check("round_start_time", $time, ref_t);
            ref_t = ref_t + PER * CLK;
          end
        end
        if (drive_en) begin
          if (run == 0) check("drive_en_starts_at_trigger", req_trigger, 1'b1);
          run++;
        end else if (run > 0) begin
          check("drive_en_window", run, req_len + 1);
          check("rx_trigger_after_drive", rx_trigger, 1'b1);
          run = 0;
        end
        if (rx_trigger) t_trig = $time;
        if (rx_abort) begin
          aborts++;
          check("abort_latency", ($time - t_trig) / CLK, TMO);
        end
        if (new_data != '0) begin
          check("new_data_onehot", $countones(new_data), 1);
          for (int p = 0; p < NP; p++) if (new_data[p]) got_nd.push_back(p);
        end
      end
    end
  end

  task automatic set_rtype();
    for (int p = 0; p < NP; p++) m_rtype[p] = PROBE ? m_present[p] : 1'b1;
  endtask

  // Predict one round from the configuration, wait for it, compare outcome.
  task automatic run_round(input string name);
    bit            got;
    logic [NP-1:0] ep;
    set_rtype();
    exp_nd.delete(); got_nd.delete(); aborts = 0; exp_aborts = 0;
    for (int p = 0; p < NP; p++) begin
      if (!stuck[p] && rx_len[p] < TMO) begin
        if (PROBE && !m_present[p]) begin
          m_present[p] = 1'b1;
        end else begin
          m_present[p] = 1'b1;
          m_data[p]    = word[p];
          exp_nd.push_back(p);
        end
      end else begin
        m_present[p] = 1'b0;
        exp_aborts++;
      end
    end
    got = 1'b0;
    for (int i = 0; i < 3 * PER && !got; i++) begin
      @(negedge sys_clk);
      if (round_done) begin
        got = 1'b1;
        check({name, ":last_port_at_done"}, port_sel, NP - 1);
      end
    end
    check({name, ":round_done_seen"}, got, 1'b1);
    for (int p = 0; p < NP; p++) ep[p] = m_present[p];
    check({name, ":port_present"}, port_present, ep);
    for (int p = 0; p < NP; p++)
      check($sformatf("%s:data[%0d]", name, p), controller_data[32*p +: 32], m_data[p]);
    check({name, ":new_data_count"}, got_nd.size(), exp_nd.size());
    for (int i = 0; i < exp_nd.size() && i < got_nd.size(); i++)
      check({name, ":new_data_order"}, got_nd[i], exp_nd[i]);
    check({name, ":abort_count"}, aborts, exp_aborts);
  endtask

  task automatic all_respond();
    for (int p = 0; p < NP; p++) begin
      stuck[p] = 1'b0; rx_len[p] = $urandom_range(1, 12); word[p] = $urandom();
    end
  endtask

  task automatic check_reset_state(input string name);
    check({name, ":drive_en"}, drive_en, 1'b0);
    check({name, ":port_sel"}, port_sel, 3'd0);
    check({name, ":port_present"}, port_present, '0);
    check({name, ":req_type"}, req_type, 1'b1);
    check({name, ":rx_abort"}, rx_abort, 1'b0);
    check({name, ":pulses"}, {req_trigger, rx_trigger, new_data, round_done}, '0);
    for (int p = 0; p < NP; p++)
      check($sformatf("%s:data[%0d]", name, p), controller_data[32*p +: 32], 32'h0);
  endtask

  initial begin : main
    bit got;
    for (int p = 0; p < NP; p++) begin
      m_data[p] = 32'h0; m_present[p] = 1'b0;
    end
    set_rtype();
    ref_t = 0;
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    check_reset_state("reset");
    sys_rst = 1'b0;
    ref_t   = $time + PER * CLK;

    // All four controllers present with the reference words.
    all_respond();
    for (int p = 0; p < NP; p++) word[p] = 32'h0080_1234 + p;
    run_round("all_present");

    // Port 2 never finishes its reply.
    all_respond();
    stuck[2] = 1'b1;
    run_round("port2_stuck");

    // Reply ends exactly at the last timeout cycle, and one cycle too late.
    all_respond();
    rx_len[1] = TMO - 1;
    rx_len[3] = TMO;
    run_round("timeout_edge");

    // Randomised presence and reply lengths.
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < NP; p++) begin
        stuck[p]  = ($urandom_range(0, 3) == 0);
        rx_len[p] = ($urandom_range(0, 3) == 0) ? TMO - 1 : $urandom_range(1, TMO - 1);
        word[p]   = $urandom();
      end
      run_round($sformatf("random%0d", r));
    end

    // Reset while port 1 is waiting on its request engine.
    all_respond();
    set_rtype();
    got = 1'b0;
    for (int i = 0; i < 3 * PER && !got; i++) begin
      @(negedge sys_clk);
      if (port_sel == 3'd1 && drive_en && !req_trigger) got = 1'b1;
    end
    check("reach_port1_send_wait", got, 1'b1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check_reset_state("mid_round_reset");
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    ref_t   = $time + PER * CLK;
    for (int p = 0; p < NP; p++) begin
      m_data[p] = 32'h0; m_present[p] = 1'b0;
    end
    all_respond();
    run_round("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/n64_poll_scheduler.md
Name: n64_poll_scheduler

Overview:
Sequences one shared N64 request engine and one shared receive engine across NUM_PORTS controller data lines, round-robin, once per poll period. Drives port select and direction enable, times out absent controllers, and latches each port's 32-bit response into a per-port register bank. Sits between the per-port tristate pads and the request/receive engines; replaces single-port polling at the top level.

Parameters:
NUM_PORTS, 4, number of controller ports polled (1..8)
POLL_PERIOD, 800000, sys_clk cycles from start of one round to start of the next (16 ms at 50 MHz)
RX_TIMEOUT, 10000, max sys_clk cycles in receive before abort (200 us)
GAP_CYCLES, 100, idle cycles between consecutive ports in a round

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst  in  1  synchronous reset, active-high
req_trigger  out  1  one-cycle start pulse to request engine
req_type  out  1  1 = data request, 0 = identity request
req_busy  in  1  request engine transmitting
rx_trigger  out  1  one-cycle start pulse to receive engine
rx_abort  out  1  one-cycle pulse forcing receive engine back to idle
rx_busy  in  1  receive engine receiving
rx_data  in  32  response word from receive engine
port_sel  out  3  index of port currently owning the engines
drive_en  out  1  1 = selected port's pad drives request engine output; 0 = tristate
controller_data  out  32*NUM_PORTS  latched response, port p at bits [32p+31:32p]
port_present  out  NUM_PORTS  bit p = last poll of port p completed without timeout
new_data  out  NUM_PORTS  one-cycle pulse when port p's word is updated
round_done  out  1  one-cycle pulse after last port of a round is handled

Behaviour:
- One clock, sys_clk. Reset is synchronous and active-high (sys_rst).
- Reset values: all pulses 0, req_type 1, port_sel 0, drive_en 0, controller_data 0, port_present 0, state WAIT_PERIOD, period counter loaded POLL_PERIOD-1 so first round starts POLL_PERIOD cycles after reset release.
- Period counter free-runs independently of state; reload at 0 raises internal start flag. Start flag while a round is in progress: held until round ends (round begins immediately after); never queued more than once.
- States:
  - WAIT_PERIOD: drive_en 0. On start flag: port_sel<=0, -> SEND.
  - SEND: drive_en 1, req_trigger 1 for exactly one cycle, -> SEND_WAIT.
  - SEND_WAIT: wait until req_trigger==0 and req_busy==0 (busy sampled no earlier than cycle after trigger); then drive_en<=0, rx_trigger 1 for one cycle, timeout counter <=0, -> RECV_WAIT.
  - RECV_WAIT: timeout counter increments each cycle. rx_busy==0 (not in trigger cycle) -> STORE. Counter reaches RX_TIMEOUT-1 with rx_busy still 1 -> rx_abort one cycle, port_present[port_sel]<=0, controller_data for port unchanged, -> GAP. Completion and timeout same cycle: completion wins.
  - STORE: controller_data[port_sel]<=rx_data, port_present bit <=1, new_data bit pulses, -> GAP.
  - GAP: count GAP_CYCLES; then if port_sel==NUM_PORTS-1: round_done pulse, -> WAIT_PERIOD; else port_sel+1, -> SEND.
- drive_en never 1 outside SEND/SEND_WAIT; exactly one port selected at any time; port_sel never exceeds NUM_PORTS-1.
- Latency per present port: 1 + request time + 1 + receive time + 1 + GAP_CYCLES.
- sys_rst mid-round: all state to reset values next edge, drive_en 0 immediately after edge; rx_abort not asserted (engines reset separately).
- Round time exceeding POLL_PERIOD is a configuration error; behaviour then is back-to-back rounds, no lost ports.

Optional Feature:
Macro N64_IDENTITY_PROBE_EN. Defined: a port with port_present==0 is sent identity request (req_type 0); successful identity response sets port_present but does not update controller_data or pulse new_data; next round that port gets data requests. Undefined: req_type constant 1; absent ports polled with data requests every round.

Test Plan:
- Reset release, all 4 ports respond with 32'h0080_1234 + p -> after first period, controller_data holds 32'h00801234..32'h00801237, port_present=4'b1111, four new_data pulses in port order, one round_done.
- Port 2 holds rx_busy high -> rx_abort exactly RX_TIMEOUT cycles after rx_trigger, port_present=4'b1011, port 2 data keeps previous value, port 3 still polled.
- rx_busy falls in same cycle timeout counter reaches RX_TIMEOUT-1 -> STORE taken, no rx_abort, present bit set.
- sys_rst asserted during port 1 SEND_WAIT -> next edge drive_en 0, port_sel 0, controller_data 0, next round starts POLL_PERIOD cycles after release.
- Check drive_en high only between req_trigger and req_busy falling across 3 rounds; period between round starts exactly 800000 cycles.
- With N64_IDENTITY_PROBE_EN, absent port 0 -> req_type 0 on its slot; after successful response, next round req_type 1, new_data[0] only on data response.
